// File: rtl/legv8_mc_control_pkg.sv
// Shared encodings for the LEGv8 multicycle control unit.
// States, opcode prefixes and datapath mux selects.
package legv8_mc_control_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_CBZ    = 4'd9,
        S_UBR    = 4'd10,
        S_BL     = 4'd11,
        S_BR     = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    localparam int OPW   = 11;
    localparam int CBZ_W = 8;
    localparam int B_W   = 6;

    localparam logic [OPW-1:0]   OP_LDUR = 11'h7C2;
    localparam logic [OPW-1:0]   OP_STUR = 11'h7C0;
    localparam logic [OPW-1:0]   OP_ADD  = 11'h458;
    localparam logic [OPW-1:0]   OP_SUB  = 11'h658;
    localparam logic [OPW-1:0]   OP_AND  = 11'h450;
    localparam logic [OPW-1:0]   OP_ORR  = 11'h550;
    localparam logic [OPW-1:0]   OP_BR   = 11'h6B0;
    localparam logic [CBZ_W-1:0] OP_CBZ  = 8'hB4;
    localparam logic [B_W-1:0]   OP_B    = 6'h05;
    localparam logic [B_W-1:0]   OP_BL   = 6'h25;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASSB = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_REGA   = 2'b10;

    typedef struct packed {
        logic ldur;
        logic stur;
        logic rtype;
        logic cbz;
        logic b;
        logic bl;
        logic br;
    } opc_cls_t;

endpackage

// File: rtl/legv8_opc_match.sv
// Prefix decoder: opcode field to one-hot instruction class.
// Nothing matching means the opcode is illegal.
module legv8_opc_match
    import legv8_mc_control_pkg::*;
(
    input  logic [OPW-1:0] op,
    output opc_cls_t       cls,
    output logic           illegal
);

    always_comb begin
        cls       = '0;
        cls.ldur  = (op == OP_LDUR);
        cls.stur  = (op == OP_STUR);
        cls.rtype = (op == OP_ADD) || (op == OP_SUB) ||
                    (op == OP_AND) || (op == OP_ORR);
        cls.cbz   = (op[10:3] == OP_CBZ);
        cls.b     = (op[10:5] == OP_B);
        cls.bl    = (op[10:5] == OP_BL);
        cls.br    = (op == OP_BR);
        illegal   = ~|cls;
    end

endmodule

// File: rtl/legv8_mc_control.sv
// LEGv8 multicycle control FSM with memory-ready handshake
// and a watchdog on every memory wait state.
module legv8_mc_control
    import legv8_mc_control_pkg::*;
#(
    parameter int MEM_TIMEOUT     = 200,
    parameter int TMO_W           = 8,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic [10:0] iOp,
    input  logic        iMemReady,
    input  logic        iZero,
    output logic        oPCWrite,
    output logic        oPCWriteCond,
    output logic        oIRWrite,
    output logic        oIorD,
    output logic        oMemRead,
    output logic        oMemWrite,
    output logic        oRegWrite,
    output logic        oReg2Loc,
    output logic        oRegDst,
    output logic        oALUSrcA,
    output logic [1:0]  oALUSrcB,
    output logic [1:0]  oOpALU,
    output logic [1:0]  oMemtoReg,
    output logic [1:0]  oPCSource,
    output logic        oIllegal,
    output logic        oMemTimeout,
    output logic [3:0]  oState
);

    state_t           state, state_n;
    logic [TMO_W-1:0] cnt;
    logic             run;
    logic             tmo;
    logic             waiting;
    logic             trip;
    opc_cls_t         cls;
    logic             bad_op;
    logic             unused_zero;

    // iZero gates the PC write inside the datapath, not here
    assign unused_zero = iZero;

    legv8_opc_match u_match (
        .op      (iOp),
        .cls     (cls),
        .illegal (bad_op)
    );

    assign waiting = (state == S_FETCH) || (state == S_MEMRD) ||
                     (state == S_MEMWR);
    assign trip    = waiting && !iMemReady &&
                     (cnt == TMO_W'(MEM_TIMEOUT - 1));

    // run delays the IDLE->FETCH step by one edge after reset release
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            run   <= 1'b0;
            tmo   <= 1'b0;
        end else begin
            state <= state_n;
            run   <= 1'b1;
            if (trip)
                tmo <= 1'b1;
            if (state_n != state)
                cnt <= '0;
            else if (waiting && !iMemReady)
                cnt <= cnt + TMO_W'(1);
        end
    end

    assign oMemTimeout = tmo;
    assign oState      = state;

    always_comb begin
        state_n      = state;
        oPCWrite     = 1'b0;
        oPCWriteCond = 1'b0;
        oIRWrite     = 1'b0;
        oIorD        = 1'b0;
        oMemRead     = 1'b0;
        oMemWrite    = 1'b0;
        oRegWrite    = 1'b0;
        oReg2Loc     = 1'b0;
        oRegDst      = 1'b0;
        oALUSrcA     = 1'b0;
        oALUSrcB     = SRCB_REG;
        oOpALU       = ALU_ADD;
        oMemtoReg    = M2R_ALU;
        oPCSource    = PCS_ALU;
        oIllegal     = 1'b0;
        unique case (state)
            S_IDLE: if (run) state_n = S_FETCH;
            S_FETCH: begin
                oMemRead = 1'b1;
                oALUSrcB = SRCB_FOUR;
                oIRWrite = iMemReady;
                oPCWrite = iMemReady;
                if (iMemReady)  state_n = S_DECODE;
                else if (trip)  state_n = S_HALT;
            end
            S_DECODE: begin
                oALUSrcB = SRCB_BOFF;
                unique case (1'b1)
                    cls.ldur, cls.stur: state_n = S_MEMADR;
                    cls.rtype:          state_n = S_EXEC;
                    cls.cbz:            state_n = S_CBZ;
                    cls.b:              state_n = S_UBR;
                    cls.bl:             state_n = S_BL;
                    cls.br:             state_n = S_BR;
                    default: begin
                        oIllegal = 1'b1;
                        state_n  = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                oALUSrcA = 1'b1;
                oALUSrcB = SRCB_IMM;
                oReg2Loc = cls.stur;
                if (cls.ldur)      state_n = S_MEMRD;
                else if (cls.stur) state_n = S_MEMWR;
                else               state_n = S_FETCH;
            end
            S_MEMRD: begin
                oMemRead = 1'b1;
                oIorD    = 1'b1;
                if (iMemReady) state_n = S_MEMWB;
                else if (trip) state_n = S_HALT;
            end
            S_MEMWB: begin
                oRegWrite = 1'b1;
                oMemtoReg = M2R_MDR;
                state_n   = S_FETCH;
            end
            S_MEMWR: begin
                oMemWrite = 1'b1;
                oIorD     = 1'b1;
                oReg2Loc  = 1'b1;
                if (iMemReady) state_n = S_FETCH;
                else if (trip) state_n = S_HALT;
            end
            S_EXEC: begin
                oALUSrcA = 1'b1;
                oOpALU   = ALU_FUNCT;
                state_n  = S_RWB;
            end
            S_RWB: begin
                oRegWrite = 1'b1;
                state_n   = S_FETCH;
            end
            S_CBZ: begin
                oReg2Loc     = 1'b1;
                oALUSrcA     = 1'b1;
                oOpALU       = ALU_PASSB;
                oPCWriteCond = 1'b1;
                oPCSource    = PCS_ALUOUT;
                state_n      = S_FETCH;
            end
            S_UBR: begin
                oPCWrite  = 1'b1;
                oPCSource = PCS_ALUOUT;
                state_n   = S_FETCH;
            end
            S_BL: begin
                oPCWrite  = 1'b1;
                oPCSource = PCS_ALUOUT;
                oRegWrite = 1'b1;
                oRegDst   = 1'b1;
                oMemtoReg = M2R_PC;
                state_n   = S_FETCH;
            end
            S_BR: begin
                oPCWrite  = 1'b1;
                oPCSource = PCS_REGA;
                state_n   = S_FETCH;
            end
            S_HALT: state_n = S_HALT;
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_legv8_mc_control.sv
// Directed bench for legv8_mc_control: instruction flows,
// memory waits, watchdog, illegal opcodes and async reset.
module tb_legv8_mc_control;

    logic        iCLK = 1'b0;
    logic        iRST_n = 1'b0;
    logic [10:0] iOp = 11'h000;
    logic        iMemReady = 1'b0;
    logic        iZero = 1'b0;

    logic        oPCWrite, oPCWriteCond, oIRWrite, oIorD, oMemRead;
    logic        oMemWrite, oRegWrite, oReg2Loc, oRegDst, oALUSrcA;
    logic [1:0]  oALUSrcB, oOpALU, oMemtoReg, oPCSource;
    logic        oIllegal, oMemTimeout;
    logic [3:0]  oState;

    logic        b_PCWrite, b_PCWriteCond, b_IRWrite, b_IorD, b_MemRead;
    logic        b_MemWrite, b_RegWrite, b_Reg2Loc, b_RegDst, b_ALUSrcA;
    logic [1:0]  b_ALUSrcB, b_OpALU, b_MemtoReg, b_PCSource;
    logic        b_Illegal, b_MemTimeout;
    logic [3:0]  b_State;

    int checks = 0;
    int errors = 0;

    logic [19:0] outs;
    assign outs = {oPCWrite, oPCWriteCond, oIRWrite, oIorD, oMemRead,
                   oMemWrite, oRegWrite, oReg2Loc, oRegDst, oALUSrcA,
                   oALUSrcB, oOpALU, oMemtoReg, oPCSource,
                   oIllegal, oMemTimeout};

    always #5 iCLK = ~iCLK;

    legv8_mc_control #(
        .MEM_TIMEOUT(4), .TMO_W(8), .HALT_ON_ILLEGAL(1'b1)
    ) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iOp(iOp),
        .iMemReady(iMemReady), .iZero(iZero),
        .oPCWrite(oPCWrite), .oPCWriteCond(oPCWriteCond),
        .oIRWrite(oIRWrite), .oIorD(oIorD), .oMemRead(oMemRead),
        .oMemWrite(oMemWrite), .oRegWrite(oRegWrite),
        .oReg2Loc(oReg2Loc), .oRegDst(oRegDst), .oALUSrcA(oALUSrcA),
        .oALUSrcB(oALUSrcB), .oOpALU(oOpALU), .oMemtoReg(oMemtoReg),
        .oPCSource(oPCSource), .oIllegal(oIllegal),
        .oMemTimeout(oMemTimeout), .oState(oState)
    );

    legv8_mc_control #(
        .MEM_TIMEOUT(4), .TMO_W(8), .HALT_ON_ILLEGAL(1'b0)
    ) dut_nop (
        .iCLK(iCLK), .iRST_n(iRST_n), .iOp(iOp),
        .iMemReady(iMemReady), .iZero(iZero),
        .oPCWrite(b_PCWrite), .oPCWriteCond(b_PCWriteCond),
        .oIRWrite(b_IRWrite), .oIorD(b_IorD), .oMemRead(b_MemRead),
        .oMemWrite(b_MemWrite), .oRegWrite(b_RegWrite),
        .oReg2Loc(b_Reg2Loc), .oRegDst(b_RegDst), .oALUSrcA(b_ALUSrcA),
        .oALUSrcB(b_ALUSrcB), .oOpALU(b_OpALU), .oMemtoReg(b_MemtoReg),
        .oPCSource(b_PCSource), .oIllegal(b_Illegal),
        .oMemTimeout(b_MemTimeout), .oState(b_State)
    );

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    // Holds reset for a cycle, releases it, expects IDLE then FETCH.
    task automatic do_reset();
        iRST_n = 1'b0;
        iMemReady = 1'b0;
        @(negedge iCLK);
        #1;
        checks++;
        if (outs !== 20'h0 || oState !== 4'd0) begin
            errors++;
            $display("FAIL reset_outs: outs=%h state=%0d want 0/0",
                     outs, oState);
        end
        iRST_n = 1'b1;
        @(negedge iCLK);
        #1;
        checks++;
        if (oState !== 4'd0) begin
            errors++;
            $display("FAIL reset_idle: state=%0d want 0", oState);
        end
        @(negedge iCLK);
        #1;
        checks++;
        if (oState !== 4'd1) begin
            errors++;
            $display("FAIL reset_fetch: state=%0d want 1", oState);
        end
    endtask

    task automatic test_reset();
        do_reset();
        iMemReady = 1'b0;
        #1;
        checks++;
        if (oMemRead !== 1'b1 || oALUSrcB !== 2'b01 ||
            oIRWrite !== 1'b0 || oPCWrite !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait: rd=%b srcb=%b irw=%b pcw=%b want 1/01/0/0",
                     oMemRead, oALUSrcB, oIRWrite, oPCWrite);
        end
    endtask

    task automatic test_add();
        int exp [5] = '{1, 2, 7, 8, 1};
        iOp = 11'h458;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge iCLK);
            iMemReady = 1'b1;
            #1;
            checks++;
            if (oState !== 4'(exp[i]) ||
                oRegWrite !== (exp[i] == 8)) begin
                errors++;
                $display("FAIL add_seq[%0d]: state=%0d rw=%b want %0d/%b",
                         i, oState, oRegWrite, exp[i], exp[i] == 8);
            end
            if (i == 0) begin
                checks++;
                if (oIRWrite !== 1'b1 || oPCWrite !== 1'b1) begin
                    errors++;
                    $display("FAIL add_fetch: irw=%b pcw=%b want 1/1",
                             oIRWrite, oPCWrite);
                end
            end
            if (i == 2) begin
                checks++;
                if (oALUSrcA !== 1'b1 || oOpALU !== 2'b10 ||
                    oALUSrcB !== 2'b00) begin
                    errors++;
                    $display("FAIL add_exec: a=%b op=%b b=%b want 1/10/00",
                             oALUSrcA, oOpALU, oALUSrcB);
                end
            end
        end
    endtask

    task automatic test_ldur();
        int   exp [9] = '{1, 2, 3, 4, 4, 4, 4, 5, 1};
        logic rdy [9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
        iOp = 11'h7C2;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge iCLK);
            iMemReady = rdy[i];
            #1;
            checks++;
            if (oState !== 4'(exp[i])) begin
                errors++;
                $display("FAIL ldur_seq[%0d]: state=%0d want %0d",
                         i, oState, exp[i]);
            end
            if (i == 1) begin
                checks++;
                if (oALUSrcB !== 2'b11 || oALUSrcA !== 1'b0) begin
                    errors++;
                    $display("FAIL decode_srcb: b=%b a=%b want 11/0",
                             oALUSrcB, oALUSrcA);
                end
            end
            if (i == 2) begin
                checks++;
                if (oALUSrcA !== 1'b1 || oALUSrcB !== 2'b10 ||
                    oReg2Loc !== 1'b0) begin
                    errors++;
                    $display("FAIL ldur_adr: a=%b b=%b r2l=%b want 1/10/0",
                             oALUSrcA, oALUSrcB, oReg2Loc);
                end
            end
            if (i == 4) begin
                checks++;
                if (oMemRead !== 1'b1 || oIorD !== 1'b1) begin
                    errors++;
                    $display("FAIL ldur_rd: rd=%b iord=%b want 1/1",
                             oMemRead, oIorD);
                end
            end
            if (i == 7) begin
                checks++;
                if (oMemtoReg !== 2'b01 || oRegWrite !== 1'b1) begin
                    errors++;
                    $display("FAIL ldur_wb: m2r=%b rw=%b want 01/1",
                             oMemtoReg, oRegWrite);
                end
            end
        end
    endtask

    task automatic test_stur();
        int exp [5] = '{1, 2, 3, 6, 1};
        iOp = 11'h7C0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge iCLK);
            iMemReady = 1'b1;
            #1;
            checks++;
            if (oState !== 4'(exp[i])) begin
                errors++;
                $display("FAIL stur_seq[%0d]: state=%0d want %0d",
                         i, oState, exp[i]);
            end
            if (i == 2 || i == 3) begin
                checks++;
                if (oReg2Loc !== 1'b1 ||
                    oMemWrite !== (i == 3) || oIorD !== (i == 3)) begin
                    errors++;
                    $display("FAIL stur_ctl[%0d]: r2l=%b wr=%b iord=%b want 1/%b/%b",
                             i, oReg2Loc, oMemWrite, oIorD, i == 3, i == 3);
                end
            end
        end
    endtask

    task automatic test_cbz();
        int exp [4] = '{1, 2, 9, 1};
        int hits = 0;
        iOp = 11'h5A0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge iCLK);
            iMemReady = 1'b1;
            iZero = i[0];
            #1;
            checks++;
            if (oState !== 4'(exp[i])) begin
                errors++;
                $display("FAIL cbz_seq[%0d]: state=%0d want %0d",
                         i, oState, exp[i]);
            end
            if (oPCWriteCond === 1'b1 && oPCSource === 2'b01) hits++;
            if (i == 2) begin
                checks++;
                if (oReg2Loc !== 1'b1 || oOpALU !== 2'b01 ||
                    oALUSrcA !== 1'b1 || oPCWrite !== 1'b0) begin
                    errors++;
                    $display("FAIL cbz_ctl: r2l=%b op=%b a=%b pcw=%b want 1/01/1/0",
                             oReg2Loc, oOpALU, oALUSrcA, oPCWrite);
                end
            end
        end
        checks++;
        if (hits !== 1) begin
            errors++;
            $display("FAIL cbz_pulse: cycles=%0d want 1", hits);
        end
        iZero = 1'b0;
    endtask

    task automatic test_branches();
        logic [10:0] ops [3] = '{11'h0A0, 11'h4A0, 11'h6B0};
        int          st  [3] = '{10, 11, 12};
        logic [1:0]  pcs [3] = '{2'b01, 2'b01, 2'b10};
        for (int k = 0; k < 3; k++) begin
            iOp = ops[k];
            iMemReady = 1'b1;
            @(negedge iCLK);
            #1;
            checks++;
            if (oState !== 4'd2) begin
                errors++;
                $display("FAIL br%0d_decode: state=%0d want 2", k, oState);
            end
            @(negedge iCLK);
            #1;
            checks++;
            if (oState !== 4'(st[k]) || oPCWrite !== 1'b1 ||
                oPCSource !== pcs[k] || oRegWrite !== (k == 1) ||
                oRegDst !== (k == 1) ||
                oMemtoReg !== ((k == 1) ? 2'b10 : 2'b00)) begin
                errors++;
                $display("FAIL br%0d_exec: st=%0d pcw=%b pcs=%b rw=%b dst=%b m2r=%b want %0d/1/%b/%b/%b",
                         k, oState, oPCWrite, oPCSource, oRegWrite, oRegDst,
                         oMemtoReg, st[k], pcs[k], k == 1, k == 1);
            end
            @(negedge iCLK);
            #1;
            checks++;
            if (oState !== 4'd1) begin
                errors++;
                $display("FAIL br%0d_ret: state=%0d want 1", k, oState);
            end
        end
    endtask

    task automatic test_timeout();
        int exp [5] = '{1, 1, 1, 1, 13};
        iOp = 11'h458;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge iCLK);
            iMemReady = 1'b0;
            #1;
            checks++;
            if (oState !== 4'(exp[i]) || oMemTimeout !== (i == 4)) begin
                errors++;
                $display("FAIL tmo_seq[%0d]: state=%0d tmo=%b want %0d/%b",
                         i, oState, oMemTimeout, exp[i], i == 4);
            end
        end
        iMemReady = 1'b1;
        @(negedge iCLK);
        #1;
        checks++;
        if (oState !== 4'd13 || outs !== 20'h1) begin
            errors++;
            $display("FAIL tmo_halt: state=%0d outs=%h want 13/00001",
                     oState, outs);
        end
        do_reset();
    endtask

    task automatic test_timeout_ready();
        int   exp [8] = '{1, 1, 1, 1, 2, 7, 8, 1};
        logic rdy [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
        iOp = 11'h658;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge iCLK);
            iMemReady = rdy[i];
            #1;
            checks++;
            if (oState !== 4'(exp[i]) || oMemTimeout !== 1'b0) begin
                errors++;
                $display("FAIL tmo_ready[%0d]: state=%0d tmo=%b want %0d/0",
                         i, oState, oMemTimeout, exp[i]);
            end
        end
    endtask

    task automatic test_illegal();
        iOp = 11'h000;
        iMemReady = 1'b1;
        @(negedge iCLK);
        #1;
        checks++;
        if (oState !== 4'd2 || oIllegal !== 1'b1 ||
            b_State !== 4'd2 || b_Illegal !== 1'b1) begin
            errors++;
            $display("FAIL ill_decode: st=%0d ill=%b nst=%0d nill=%b want 2/1/2/1",
                     oState, oIllegal, b_State, b_Illegal);
        end
        @(negedge iCLK);
        #1;
        checks++;
        if (oState !== 4'd13 || outs !== 20'h0 ||
            b_State !== 4'd1 || b_Illegal !== 1'b0) begin
            errors++;
            $display("FAIL ill_next: st=%0d outs=%h nst=%0d nill=%b want 13/0/1/0",
                     oState, outs, b_State, b_Illegal);
        end
        @(negedge iCLK);
        #1;
        checks++;
        if (oState !== 4'd13 || oIllegal !== 1'b0) begin
            errors++;
            $display("FAIL ill_hold: st=%0d ill=%b want 13/0", oState, oIllegal);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_memwr();
        int   exp [4] = '{1, 2, 3, 6};
        logic rdy [4] = '{1, 1, 1, 0};
        iOp = 11'h7C0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge iCLK);
            iMemReady = rdy[i];
            #1;
            checks++;
            if (oState !== 4'(exp[i])) begin
                errors++;
                $display("FAIL memwr_seq[%0d]: state=%0d want %0d",
                         i, oState, exp[i]);
            end
        end
        checks++;
        if (oMemWrite !== 1'b1) begin
            errors++;
            $display("FAIL memwr_hold: wr=%b want 1", oMemWrite);
        end
        iRST_n = 1'b0;
        #1;
        checks++;
        if (outs !== 20'h0 || oState !== 4'd0) begin
            errors++;
            $display("FAIL async_rst: outs=%h state=%0d want 0/0",
                     outs, oState);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldur();
        test_stur();
        test_cbz();
        test_branches();
        test_timeout();
        test_timeout_ready();
        test_illegal();
        test_reset_mid_memwr();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
